// File: rtl/reg_file_n.sv
// reg_file_n: parametrised register file with one bus write, one combinational
// bus read, a PSW flags register and a scoreboarded writeback port for
// multi-cycle units that return a low and an optional high result word.
module reg_file_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_oe,
  output logic                  stall,
  input  logic                  ext_start,
  input  logic [AW-1:0]         ext_lo_addr,
  input  logic [AW-1:0]         ext_hi_addr,
  input  logic                  ext_hi_en,
  output logic                  ext_ready,
  input  logic                  ext_valid,
  input  logic [WIDTH-1:0]      ext_lo_data,
  input  logic [WIDTH-1:0]      ext_hi_data,
  output logic [NREG-1:0]       busy,
  input  logic                  flags_we,
  input  logic [WIDTH-1:0]      flags_mask,
  input  logic [WIDTH-1:0]      flags_in,
  output logic [WIDTH-1:0]      flags_out,
  output logic [NREG*WIDTH-1:0] dshow
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     regs_q [NREG];
  logic [WIDTH-1:0]     regs_d [NREG];
  logic [WIDTH-1:0]     flags_q, flags_d;
  logic [NREG-1:0]      busy_q, busy_d;
  logic [AW-1:0]        lo_addr_q, lo_addr_d;
  logic [AW-1:0]        hi_addr_q, hi_addr_d;
  logic                 hi_en_q, hi_en_d;

  logic                 wr_ok;
  logic                 rd_ok;

  // Bus requests are granted only when the addressed register is not locked.
  always_comb begin
    wr_ok   = wr_en && !busy_q[wr_addr];
    rd_ok   = rd_en && !busy_q[rd_addr];
    stall   = (wr_en && busy_q[wr_addr]) || (rd_en && busy_q[rd_addr]);
    dout_oe = rd_ok;
    dout    = rd_ok ? regs_q[rd_addr] : '0;
  end

  // Writeback FSM, busy scoreboard, register and flags next-state.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    lo_addr_d = lo_addr_q;
    hi_addr_d = hi_addr_q;
    hi_en_d   = hi_en_q;
    flags_d   = flags_q;
    regs_d    = regs_q;

    // Bus write lands first; ext targets are locked so they never collide,
    // and on a same-cycle ext_start the lock only applies from next cycle.
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (ext_start) begin
          lo_addr_d           = ext_lo_addr;
          hi_addr_d           = ext_hi_addr;
          hi_en_d             = ext_hi_en;
          busy_d              = '0;
          busy_d[ext_lo_addr] = 1'b1;
          if (ext_hi_en) begin
            busy_d[ext_hi_addr] = 1'b1;
          end
          state_d = PEND;
        end
      end
      PEND: begin
        if (ext_valid) begin
          regs_d[lo_addr_q] = ext_lo_data;
          // High word is written last so it wins when both addresses match.
          if (hi_en_q) begin
            regs_d[hi_addr_q] = ext_hi_data;
          end
          busy_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flags_we) begin
      flags_d = (flags_q & ~flags_mask) | (flags_in & flags_mask);
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      lo_addr_q <= '0;
      hi_addr_q <= '0;
      hi_en_q   <= 1'b0;
      flags_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      lo_addr_q <= lo_addr_d;
      hi_addr_q <= hi_addr_d;
      hi_en_q   <= hi_en_d;
      flags_q   <= flags_d;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign ext_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign flags_out = flags_q;

  // Debug view of all registers, register k in slice k.
  for (genvar k = 0; k < int'(NREG); k++) begin : g_dshow
    assign dshow[k*WIDTH +: WIDTH] = regs_q[k];
  end

endmodule
